seq_det_ctrl: RTL and testbench
===============================

SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter MAX_LEN, default 8: maximum pattern length in bits.
REQ-002 Parameter CNT_W, default 8: width of the match counter and the target register.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port cfg_we, input, 1: configuration write strobe.
REQ-006 Port cfg_pattern, input, MAX_LEN: pattern; the bit at index 0 is the last bit received.
REQ-007 Port cfg_len, input, 4: pattern length in bits.
REQ-008 Port cfg_overlap, input, 1: 1 = overlapping detection, 0 = non-overlapping.
REQ-009 Port cfg_target, input, CNT_W: number of matches that ends a run; 0 = unlimited.
REQ-010 Port start, input, 1: begin a detection run.
REQ-011 Port stop, input, 1: abort or finish a run.
REQ-012 Port ip, input, 1: serial data bit.
REQ-013 Port ip_valid, input, 1: ip is sampled only when this is 1.
REQ-014 Port busy, output, 1: high in RUN.
REQ-015 Port match, output, 1: one-cycle detection pulse.
REQ-016 Port match_cnt, output, CNT_W: matches counted in the current or last run.
REQ-017 Port done, output, 1: high in DONE.

Function
REQ-018 The block SHALL implement a state machine with three states: IDLE, RUN and DONE.
REQ-019 In IDLE only, cfg_we SHALL latch pattern, length, overlap and target; cfg_we SHALL be ignored in RUN and DONE.
REQ-020 A latched cfg_len below 2 SHALL be treated as 2, and a value above MAX_LEN SHALL be treated as MAX_LEN.
REQ-021 start in IDLE or DONE SHALL clear the history register, bits_seen and match_cnt, and enter RUN on the next cycle.
REQ-022 In RUN, each cycle with ip_valid=1 SHALL shift ip into bit 0 of the history and increment bits_seen, saturating at len.
REQ-023 Detection condition: after an update, bits_seen==len and the low len bits of the history equal the low len bits of the pattern.
REQ-024 On detection, match SHALL be 1 in the cycle after the completing bit edge, for exactly one cycle (registered, Moore style).
REQ-025 On detection with overlap=0, bits_seen SHALL clear to 0.
REQ-026 On detection with overlap=1, bits_seen SHALL be kept, so matches may share bits.
REQ-027 Cycles with ip_valid=0 SHALL change neither the history nor bits_seen.
REQ-028 Each match SHALL increment match_cnt, which saturates at 2^CNT_W-1 with no wrap.
REQ-029 When target!=0 and match_cnt reaches target, the FSM SHALL enter DONE in the same cycle that match is high.
REQ-030 In DONE, further ip SHALL be ignored.
REQ-031 stop in RUN or DONE SHALL return the FSM to IDLE next cycle and keep match_cnt.
REQ-032 stop in IDLE SHALL have no effect.
REQ-033 start and stop in the same cycle: stop SHALL win.
REQ-034 start while in RUN SHALL be ignored.
REQ-035 A detection in the same cycle as stop SHALL still pulse match and count the match, then go to IDLE.
REQ-036 match SHALL never be asserted in IDLE.

Reset
REQ-037 When reset=0, the block SHALL immediately force state=IDLE, busy=0, match=0, done=0 and match_cnt=0.
REQ-038 When reset=0, the block SHALL also clear the history register, bits_seen and every configuration register (pattern=0, len=2, overlap=0, target=0).
REQ-039 Reset asserted mid-run SHALL abort with no further match pulse; after release the block SHALL wait in IDLE.

Verification
REQ-040 pattern=1001, len=4, overlap=1, target=0; ip 1,0,0,1,0,0,1 -> match pulses after bits 4 and 7; match_cnt=2.
REQ-041 Same input stream with overlap=0 -> exactly one match pulse, after bit 4; match_cnt=1.
REQ-042 target=2, overlap=1, stream 1001001001 -> done=1 and busy=0 in the cycle of the 2nd match; the 3rd pattern is not counted.
REQ-043 cfg_we with pattern=1111 during RUN -> ignored; 1001 is still detected; a new start after stop uses the old config.
REQ-044 ip_valid toggled 1,0,1,0 between the bits of 1001 -> a single match, aligned to the 4th valid bit.
REQ-045 reset pulsed low after 3 bits, then 1 bit applied -> no match, match_cnt=0, state IDLE; CNT_W=2 with 5 matches -> match_cnt stays at 3.

Source files
------------

// File: rtl/seq_det_ctrl.sv
// Serial pattern detector with a configurable pattern, length, overlap mode and
// match target. The FSM runs IDLE -> RUN -> DONE, and the match pulse is registered.
module seq_det_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_target,
    input  logic               start,
    input  logic               stop,
    input  logic               ip,
    input  logic               ip_valid,
    output logic               busy,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, hist_q, hist_d, mask;
    logic [3:0]         len_q, len_in, seen_q, seen_d;
    logic               ov_q;
    logic [CNT_W-1:0]   tgt_q, cnt_q, cnt_d;
    logic               match_q, match_d, pend_q, pend_d, cfg_ld, hit;

    always_comb begin
        if (cfg_len < 4'd2)
            len_in = 4'd2;
        else if (int'(cfg_len) > MAX_LEN)
            len_in = 4'(MAX_LEN);
        else
            len_in = cfg_len;
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (i < int'(len_q));
    end

    // A detection coinciding with stop is held in RUN for one cycle (pend_q)
    // so the match pulse never lands in IDLE.
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        seen_d  = seen_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;
        pend_d  = 1'b0;
        cfg_ld  = 1'b0;
        hit     = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_ld = cfg_we;
                if (start && !stop) begin
                    state_d = RUN;
                    hist_d  = '0;
                    seen_d  = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (pend_q) begin
                    state_d = IDLE;
                end else begin
                    if (ip_valid) begin
                        hist_d = {hist_q[MAX_LEN-2:0], ip};
                        seen_d = (seen_q < len_q) ? seen_q + 4'd1 : len_q;
                        hit    = (seen_d == len_q) && ((hist_d & mask) == (pat_q & mask));
                    end
                    if (hit) begin
                        match_d = 1'b1;
                        if (!ov_q)
                            seen_d = '0;
                        if (cnt_q != '1)
                            cnt_d = cnt_q + 1'b1;
                    end
                    if (hit && tgt_q != '0 && cnt_d == tgt_q) begin
                        state_d = DONE;
                        pend_d  = stop;
                    end else if (stop) begin
                        if (hit)
                            pend_d = 1'b1;
                        else
                            state_d = IDLE;
                    end
                end
            end
            DONE: begin
                if (stop || pend_q) begin
                    state_d = IDLE;
                end else if (start) begin
                    state_d = RUN;
                    hist_d  = '0;
                    seen_d  = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            hist_q  <= '0;
            seen_q  <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
            pend_q  <= 1'b0;
            pat_q   <= '0;
            len_q   <= 4'd2;
            ov_q    <= 1'b0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            seen_q  <= seen_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            pend_q  <= pend_d;
            if (cfg_ld) begin
                pat_q <= cfg_pattern;
                len_q <= len_in;
                ov_q  <= cfg_overlap;
                tgt_q <= cfg_target;
            end
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign match     = match_q;
    assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl: streams hand-written bit vectors and checks
// match/count/state against hand-computed expectations.
module tb_seq_det_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic [7:0] cfg_target = '0;
    logic       start = 1'b0, stop = 1'b0, ip = 1'b0, ip_valid = 1'b0;
    logic       busy, match, done;
    logic [7:0] match_cnt;
    logic       busy2, match2, done2;
    logic [1:0] match_cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_det_ctrl #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
        .start(start), .stop(stop), .ip(ip), .ip_valid(ip_valid),
        .busy(busy), .match(match), .match_cnt(match_cnt), .done(done)
    );

    seq_det_ctrl #(.MAX_LEN(8), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target[1:0]),
        .start(start), .stop(stop), .ip(ip), .ip_valid(ip_valid),
        .busy(busy2), .match(match2), .match_cnt(match_cnt2), .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic ov, input logic [7:0] t);
        @(negedge clk);
        cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = ov; cfg_target = t;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
    endtask

    // Feeds b MSB-first (n bits), checks match after each edge against e.
    task automatic run(input logic [15:0] b, input logic [15:0] v, input logic [15:0] e,
                       input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk); ip = b[i]; ip_valid = v[i];
            @(posedge clk); #1;
            chk($sformatf("%s[%0d]", tag, n - 1 - i), {31'b0, match}, {31'b0, e[i]});
        end
        @(negedge clk); ip_valid = 1'b0;
    endtask

    initial begin
        #12 chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_match", {31'b0, match}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_cnt", match_cnt, 0);
        @(negedge clk); reset = 1'b1;

        pulse_stop();
        chk("stop_idle", {31'b0, busy}, 0);
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        chk("start_stop_idle", {31'b0, busy}, 0);

        // overlapping
        cfg(8'h09, 4'd4, 1'b1, 8'd0);
        pulse_start();
        chk("run_busy", {31'b0, busy}, 1);
        run(16'b1001001, 16'h7F, 16'b0001001, 7, "ovl");
        chk("ovl_cnt", match_cnt, 2);
        pulse_stop();

        // non-overlapping
        cfg(8'h09, 4'd4, 1'b0, 8'd0);
        pulse_start();
        run(16'b1001001, 16'h7F, 16'b0001000, 7, "novl");
        chk("novl_cnt", match_cnt, 1);
        pulse_stop();
        chk("stop_keeps_cnt", match_cnt, 1);

        // target
        cfg(8'h09, 4'd4, 1'b1, 8'd2);
        pulse_start();
        run(16'b1001001, 16'h7F, 16'b0001001, 7, "tgt");
        chk("tgt_done", {31'b0, done}, 1);
        chk("tgt_busy", {31'b0, busy}, 0);
        chk("tgt_cnt", match_cnt, 2);
        run(16'b001, 16'h7, 16'b000, 3, "tgt_ign");
        chk("tgt_cnt_after", match_cnt, 2);
        pulse_stop();
        chk("done_stop", {31'b0, done}, 0);

        // cfg ignored while running
        cfg(8'h09, 4'd4, 1'b1, 8'd0);
        pulse_start();
        cfg(8'h0F, 4'd4, 1'b1, 8'd0);
        run(16'b1001, 16'hF, 16'b0001, 4, "cfgrun");
        pulse_stop();
        pulse_start();
        run(16'b11111001, 16'hFF, 16'b00000001, 8, "oldcfg");
        pulse_stop();

        // ip_valid gaps
        pulse_start();
        run(16'b1001011, 16'b1010101, 16'b0000001, 7, "gap");
        chk("gap_cnt", match_cnt, 1);
        pulse_stop();

        // detection coincident with stop
        pulse_start();
        run(16'b100, 16'h7, 16'b000, 3, "sm");
        @(negedge clk); ip = 1'b1; ip_valid = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        chk("stop_match", {31'b0, match}, 1);
        chk("stop_match_cnt", match_cnt, 1);
        @(negedge clk); stop = 1'b0; ip_valid = 1'b0;
        @(posedge clk); #1;
        chk("stop_match_idle", {31'b0, busy}, 0);
        chk("stop_match_clr", {31'b0, match}, 0);
        @(posedge clk); #1;
        chk("stop_match_stays_idle", {31'b0, busy}, 0);

        // reset mid-run
        pulse_start();
        run(16'b1001100, 16'h7F, 16'b0001000, 7, "prerst");
        @(negedge clk); reset = 1'b0; #1;
        chk("arst_busy", {31'b0, busy}, 0);
        chk("arst_cnt", match_cnt, 0);
        @(negedge clk); reset = 1'b1;
        run(16'b1, 16'h1, 16'b0, 1, "postrst");
        chk("postrst_cnt", match_cnt, 0);
        chk("postrst_busy", {31'b0, busy}, 0);

        // reset config: pattern 0, len 2, no overlap
        pulse_start();
        run(16'b1000, 16'hF, 16'b0010, 4, "rstcfg");
        pulse_stop();

        // length clamping
        cfg(8'h01, 4'd1, 1'b0, 8'd0);
        pulse_start();
        run(16'b1101, 16'hF, 16'b0001, 4, "lenlo");
        pulse_stop();
        cfg(8'hA5, 4'd15, 1'b0, 8'd0);
        pulse_start();
        run(16'b10100101, 16'hFF, 16'b00000001, 8, "lenhi");
        pulse_stop();

        // counter saturation on the narrow instance
        cfg(8'h09, 4'd4, 1'b1, 8'd0);
        pulse_start();
        run(16'b1001001001001001, 16'hFFFF, 16'h1249, 16, "sat");
        chk("sat_cnt8", match_cnt, 5);
        chk("sat_cnt2", {30'b0, match_cnt2}, 3);
        pulse_stop();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
